// File: rtl/host_cmd_master_pkg.sv
// rtl/host_cmd_master_pkg.sv - shared constants, types and frame tables for host_cmd_master
// Purpose: frame opcodes, request command encodings, FSM state encoding, captured
//          request record, and the per-command TX length / RX count lookup.
// Ports:   none (package).
package host_cmd_master_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        REQ_RF_WR   = 2'd0,
        REQ_RF_RD   = 2'd1,
        REQ_ALU_OP  = 2'd2,
        REQ_ALU_NOP = 2'd3
    } req_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef struct packed {
        req_cmd_t   cmd;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] fun;
    } req_t;

    // Number of frame bytes sent toward the UART for each command.
    function automatic logic [2:0] cmd_tx_len(req_cmd_t c);
        case (c)
            REQ_RF_WR:   return 3'd3;
            REQ_RF_RD:   return 3'd2;
            REQ_ALU_OP:  return 3'd4;
            REQ_ALU_NOP: return 3'd2;
            default:     return 3'd2;
        endcase
    endfunction

    // Number of response bytes expected back from the controller.
    function automatic logic [1:0] cmd_rx_cnt(req_cmd_t c);
        case (c)
            REQ_RF_WR:   return 2'd0;
            REQ_RF_RD:   return 2'd1;
            REQ_ALU_OP:  return 2'd2;
            REQ_ALU_NOP: return 2'd2;
            default:     return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/host_cmd_master_if.sv
// rtl/host_cmd_master_if.sv - request, UART byte and response signal bundle
// Purpose: groups the request handshake, UART TX/RX byte streams and response outputs.
// Modports: master = host_cmd_master side; slave = requester / UART / harness side.
interface host_cmd_master_if;
    logic        REQ_VLD;
    logic        REQ_RDY;
    logic [1:0]  REQ_CMD;
    logic [3:0]  REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic [7:0]  REQ_OPA;
    logic [7:0]  REQ_OPB;
    logic [3:0]  REQ_FUN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_BUSY;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_TIMEOUT;

    modport master (
        input  REQ_VLD, REQ_CMD, REQ_ADDR, REQ_WDATA, REQ_OPA, REQ_OPB, REQ_FUN,
        input  TX_BUSY, RX_P_DATA, RX_D_VLD,
        output REQ_RDY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT
    );

    modport slave (
        output REQ_VLD, REQ_CMD, REQ_ADDR, REQ_WDATA, REQ_OPA, REQ_OPB, REQ_FUN,
        output TX_BUSY, RX_P_DATA, RX_D_VLD,
        input  REQ_RDY, TX_P_DATA, TX_D_VLD, RSP_DATA, RSP_VLD, RSP_TIMEOUT
    );
endinterface

// File: rtl/host_cmd_master_rsp_timer.sv
// rtl/host_cmd_master_rsp_timer.sv - clearable response timeout counter
// Purpose: counts cycles since the last clear; expire is high once the count
//          reaches TIMEOUT_CYCLES-1 and the counter parks there until cleared.
// Ports:   clk, rst (sync active-high), clr (synchronous clear), expire (out).
module host_cmd_master_rsp_timer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expire
);
    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] ONE  = TMR_W'(1);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (!expire) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign expire = (cnt_q == LAST);
endmodule

// File: rtl/host_cmd_master.sv
// rtl/host_cmd_master.sv - host-side command frame serialiser and response collector
// Purpose: accepts one command request, sends its frame bytes to the UART TX,
//          gathers the response bytes from the UART RX and reports a 16-bit
//          result with a completion pulse, or a timeout pulse.
// Ports:   CLK, RST (sync active-high), bus (host_cmd_master_if.master):
//          REQ_* request handshake/fields, TX_* byte out, RX_* byte in, RSP_* result.
module host_cmd_master
    import host_cmd_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TMR_W          = 13
) (
    input  logic                  CLK,
    input  logic                  RST,
    host_cmd_master_if.master     bus
);
    state_t      state_q, state_d;
    req_t        req_q;
    logic [1:0]  idx_q;
    logic [1:0]  rx_cnt_q;
    logic [15:0] rsp_q;

    logic        accept;
    logic        tx_xfer;
    logic        tx_last;
    logic        rx_take;
    logic        rx_last;
    logic        expire;
    logic        timeout_hit;
    logic        timer_clr;
    logic [2:0]  tx_len;
    logic [1:0]  rx_exp;
    logic [7:0]  frame_byte;

    assign tx_len  = cmd_tx_len(req_q.cmd);
    assign rx_exp  = cmd_rx_cnt(req_q.cmd);
    assign accept  = (state_q == ST_IDLE) && bus.REQ_VLD;
    assign tx_xfer = (state_q == ST_SEND) && !bus.TX_BUSY;
    assign tx_last = ({1'b0, idx_q} == (tx_len - 3'd1));
    assign rx_take = (state_q == ST_WAIT_RSP) && bus.RX_D_VLD;
    assign rx_last = ((rx_cnt_q + 2'd1) == rx_exp);
    // A byte landing in the expiry cycle wins over the timeout.
    assign timeout_hit = (state_q == ST_WAIT_RSP) && expire && !bus.RX_D_VLD;
    // Held clear outside WAIT_RSP so the count starts at zero on entry.
    assign timer_clr = (state_q != ST_WAIT_RSP) || bus.RX_D_VLD;

    host_cmd_master_rsp_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_rsp_timer (
        .clk    (CLK),
        .rst    (RST),
        .clr    (timer_clr),
        .expire (expire)
    );

    // Frame byte selected by the captured command and the current byte index.
    always_comb begin
        frame_byte = 8'h00;
        case (req_q.cmd)
            REQ_RF_WR: begin
                case (idx_q)
                    2'd0:    frame_byte = CMD_RF_WR;
                    2'd1:    frame_byte = {4'h0, req_q.addr};
                    default: frame_byte = req_q.wdata;
                endcase
            end
            REQ_RF_RD: begin
                if (idx_q == 2'd0) frame_byte = CMD_RF_RD;
                else               frame_byte = {4'h0, req_q.addr};
            end
            REQ_ALU_OP: begin
                case (idx_q)
                    2'd0:    frame_byte = CMD_ALU_OP;
                    2'd1:    frame_byte = req_q.opa;
                    2'd2:    frame_byte = req_q.opb;
                    default: frame_byte = {4'h0, req_q.fun};
                endcase
            end
            REQ_ALU_NOP: begin
                if (idx_q == 2'd0) frame_byte = CMD_ALU_NOP;
                else               frame_byte = {4'h0, req_q.fun};
            end
            default: frame_byte = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ_VLD) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_xfer && tx_last) begin
                    state_d = (rx_exp != 2'd0) ? ST_WAIT_RSP : ST_DONE;
                end
            end
            ST_WAIT_RSP: begin
                if (rx_take && rx_last) state_d = ST_DONE;
                else if (timeout_hit)   state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.REQ_RDY     = (state_q == ST_IDLE);
        bus.TX_D_VLD    = (state_q == ST_SEND);
        bus.TX_P_DATA   = (state_q == ST_SEND) ? frame_byte : 8'h00;
        bus.RSP_VLD     = (state_q == ST_DONE);
        bus.RSP_TIMEOUT = timeout_hit;
    end

    // Request capture, byte index and response assembly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_q    <= '0;
            idx_q    <= 2'd0;
            rx_cnt_q <= 2'd0;
            rsp_q    <= 16'h0000;
        end else begin
            if (accept) begin
                req_q.cmd   <= req_cmd_t'(bus.REQ_CMD);
                req_q.addr  <= bus.REQ_ADDR;
                req_q.wdata <= bus.REQ_WDATA;
                req_q.opa   <= bus.REQ_OPA;
                req_q.opb   <= bus.REQ_OPB;
                req_q.fun   <= bus.REQ_FUN;
                idx_q       <= 2'd0;
                rx_cnt_q    <= 2'd0;
                rsp_q       <= 16'h0000;
            end
            if (tx_xfer) begin
                idx_q <= idx_q + 2'd1;
            end
            if (rx_take) begin
                if (rx_cnt_q == 2'd0) rsp_q[7:0]  <= bus.RX_P_DATA;
                else                  rsp_q[15:8] <= bus.RX_P_DATA;
                rx_cnt_q <= rx_cnt_q + 2'd1;
            end
        end
    end

    assign bus.RSP_DATA = rsp_q;
endmodule

// File: tb/tb_host_cmd_master.sv
// tb/tb_host_cmd_master.sv - self-checking bench for host_cmd_master
module tb_host_cmd_master;
    localparam int T = 4096;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    host_cmd_master_if bus();

    host_cmd_master #(.TIMEOUT_CYCLES(T), .TMR_W(13)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Protocol-level model: a queue of frame bytes still to send, a count of
    // response bytes still owed, and the number of silent cycles in the wait.
    logic [7:0]  m_txq[$];
    int          m_need, m_got, m_silence;
    bit          m_live = 0, m_active = 0, m_wait = 0, m_done = 0;
    logic [15:0] m_data = 16'h0000;

    always @(posedge CLK) begin
        if (RST) begin
            m_live = 1; m_active = 0; m_wait = 0; m_done = 0;
            m_txq.delete(); m_data = 16'h0000;
        end else if (m_live) begin
            if (m_done) begin
                m_done = 0; m_active = 0;
            end else if (!m_active) begin
                if (bus.REQ_VLD) begin
                    m_active = 1; m_data = 16'h0000; m_got = 0;
                    m_txq.delete();
                    case (bus.REQ_CMD)
                        2'd0: begin
                            m_txq.push_back(8'hAA); m_txq.push_back({4'h0, bus.REQ_ADDR});
                            m_txq.push_back(bus.REQ_WDATA); m_need = 0;
                        end
                        2'd1: begin
                            m_txq.push_back(8'hBB); m_txq.push_back({4'h0, bus.REQ_ADDR}); m_need = 1;
                        end
                        2'd2: begin
                            m_txq.push_back(8'hCC); m_txq.push_back(bus.REQ_OPA);
                            m_txq.push_back(bus.REQ_OPB); m_txq.push_back({4'h0, bus.REQ_FUN}); m_need = 2;
                        end
                        default: begin
                            m_txq.push_back(8'hDD); m_txq.push_back({4'h0, bus.REQ_FUN}); m_need = 2;
                        end
                    endcase
                end
            end else if (m_txq.size() != 0) begin
                if (!bus.TX_BUSY) begin
                    void'(m_txq.pop_front());
                    if (m_txq.size() == 0) begin
                        if (m_need == 0) m_done = 1;
                        else begin m_wait = 1; m_silence = 0; end
                    end
                end
            end else if (m_wait) begin
                if (bus.RX_D_VLD) begin
                    if (m_got == 0) m_data[7:0] = bus.RX_P_DATA;
                    else            m_data[15:8] = bus.RX_P_DATA;
                    m_got++; m_silence = 0;
                    if (m_got == m_need) begin m_wait = 0; m_done = 1; end
                end else if (m_silence == T - 1) begin
                    m_wait = 0; m_active = 0;
                end else begin
                    m_silence++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic [27:0] exp_v, act_v;
        logic        e_txv, e_to;
        logic [7:0]  e_txd;
        if (m_live) begin
            e_txv = (m_txq.size() != 0);
            e_txd = e_txv ? m_txq[0] : 8'h00;
            e_to  = m_wait && (m_silence == T - 1) && !bus.RX_D_VLD;
            exp_v = {!m_active, e_txv, e_txd, m_done, e_to, m_data};
            act_v = {bus.REQ_RDY, bus.TX_D_VLD, bus.TX_P_DATA, bus.RSP_VLD, bus.RSP_TIMEOUT, bus.RSP_DATA};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_model actual=%h required=%h t=%0t", act_v, exp_v, $time);
            end
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic issue(input logic [1:0] cmd, input logic [3:0] addr, input logic [7:0] wdata,
                         input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun);
        bus.REQ_CMD = cmd; bus.REQ_ADDR = addr; bus.REQ_WDATA = wdata;
        bus.REQ_OPA = opa; bus.REQ_OPB = opb; bus.REQ_FUN = fun;
        bus.REQ_VLD = 1'b1;
        tick();
        bus.REQ_VLD = 1'b0;
        bus.REQ_CMD = 2'($urandom); bus.REQ_ADDR = 4'($urandom); bus.REQ_WDATA = 8'($urandom);
        bus.REQ_OPA = 8'($urandom); bus.REQ_OPB = 8'($urandom); bus.REQ_FUN = 4'($urandom);
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.RX_P_DATA = b; bus.RX_D_VLD = 1'b1;
        tick();
        bus.RX_D_VLD = 1'b0; bus.RX_P_DATA = 8'($urandom);
    endtask

    task automatic wait_rsp(input int bound, output int n, output logic vld, output logic to,
                            output logic [15:0] data);
        bit hit = 0;
        n = 0; vld = 0; to = 0; data = 16'h0000;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge CLK);
            n++;
            if (bus.RSP_VLD || bus.RSP_TIMEOUT) begin
                hit = 1; vld = bus.RSP_VLD; to = bus.RSP_TIMEOUT; data = bus.RSP_DATA;
            end
            tick();
        end
        chk("rsp_arrived", 32'(hit), 32'd1);
    endtask

    initial begin
        int n, got;
        logic vld, to;
        logic [15:0] data;
        logic [7:0] e1[3];
        logic [7:0] e3[4];
        logic [7:0] seen[4];

        bus.REQ_VLD = 0; bus.REQ_CMD = 0; bus.REQ_ADDR = 0; bus.REQ_WDATA = 0;
        bus.REQ_OPA = 0; bus.REQ_OPB = 0; bus.REQ_FUN = 0;
        bus.TX_BUSY = 0; bus.RX_P_DATA = 0; bus.RX_D_VLD = 0;
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;

        @(negedge CLK);
        chk("reset_req_rdy", 32'(bus.REQ_RDY), 32'd1);
        chk("reset_tx_vld", 32'(bus.TX_D_VLD), 32'd0);
        chk("reset_tx_data", 32'(bus.TX_P_DATA), 32'd0);
        chk("reset_rsp", {13'd0, bus.RSP_VLD, bus.RSP_TIMEOUT, 1'b0, bus.RSP_DATA}, 32'd0);
        tick();

        // RF write: three back-to-back bytes, then completion with zero data.
        e1[0] = 8'hAA; e1[1] = 8'h05; e1[2] = 8'h3C;
        issue(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("wr_tx_vld", 32'(bus.TX_D_VLD), 32'd1);
            chk("wr_tx_byte", 32'(bus.TX_P_DATA), 32'(e1[i]));
            tick();
        end
        @(negedge CLK);
        chk("wr_rsp_vld", 32'(bus.RSP_VLD), 32'd1);
        chk("wr_rsp_data", 32'(bus.RSP_DATA), 32'h0000);
        tick();

        // RF read: response byte 40 cycles after the last TX byte.
        issue(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'h0);
        tick(); tick();
        repeat (39) tick();
        rx_byte(8'h5A);
        wait_rsp(10, n, vld, to, data);
        chk("rd_latency", 32'(n), 32'd1);
        chk("rd_vld", {31'd0, vld}, 32'd1);
        chk("rd_data", {16'd0, data}, 32'h005A);

        // ALU op with TX_BUSY toggling: each byte transferred exactly once.
        e3[0] = 8'hCC; e3[1] = 8'h10; e3[2] = 8'h03; e3[3] = 8'h02;
        issue(2'd2, 4'd0, 8'h00, 8'h10, 8'h03, 4'h2);
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            bus.TX_BUSY = (c % 2 == 0);
            @(negedge CLK);
            if (bus.TX_D_VLD && !bus.TX_BUSY) begin
                seen[got] = bus.TX_P_DATA;
                got++;
            end
            tick();
        end
        bus.TX_BUSY = 1'b0;
        chk("alu_tx_count", 32'(got), 32'd4);
        for (int i = 0; i < 4; i++) chk("alu_tx_byte", 32'(seen[i]), 32'(e3[i]));
        rx_byte(8'h30);
        repeat (3) tick();
        rx_byte(8'h00);
        wait_rsp(10, n, vld, to, data);
        chk("alu_vld", {31'd0, vld}, 32'd1);
        chk("alu_data", {16'd0, data}, 32'h0030);
        rx_byte(8'hEE);
        repeat (3) tick();

        // ALU no-operand: one byte then silence -> timeout T cycles later.
        issue(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'h0);
        tick(); tick();
        repeat (4) tick();
        rx_byte(8'h7F);
        wait_rsp(T + 10, n, vld, to, data);
        chk("to_delay", 32'(n), 32'(T));
        chk("to_pulse", {30'd0, to, vld}, 32'd2);
        chk("to_data", {16'd0, data}, 32'h007F);
        @(negedge CLK);
        chk("to_req_rdy", 32'(bus.REQ_RDY), 32'd1);
        tick();

        // RF read with no response at all: timeout T cycles after the last TX byte.
        issue(2'd1, 4'd7, 8'h00, 8'h00, 8'h00, 4'h0);
        tick(); tick();
        wait_rsp(T + 10, n, vld, to, data);
        chk("to0_delay", 32'(n), 32'(T));
        chk("to0_pulse", {30'd0, to, vld}, 32'd2);
        chk("to0_data", {16'd0, data}, 32'h0000);

        // Byte arriving in the expiry cycle is captured, no timeout.
        issue(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'h5);
        tick(); tick();
        rx_byte(8'h11);
        repeat (T - 1) tick();
        rx_byte(8'h22);
        wait_rsp(5, n, vld, to, data);
        chk("edge_latency", 32'(n), 32'd1);
        chk("edge_pulse", {30'd0, to, vld}, 32'd1);
        chk("edge_data", {16'd0, data}, 32'h2211);

        // Reset during SEND after the second byte.
        issue(2'd2, 4'd0, 8'h00, 8'h01, 8'h02, 4'h3);
        tick(); tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_tx_vld", 32'(bus.TX_D_VLD), 32'd0);
        chk("rst_req_rdy", 32'(bus.REQ_RDY), 32'd1);
        tick();
        rx_byte(8'h99);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("rst_quiet", {13'd0, bus.RSP_VLD, bus.RSP_TIMEOUT, bus.TX_D_VLD, bus.RSP_DATA}, 32'd0);
            tick();
        end

        // Normal read after the abandoned transaction.
        issue(2'd1, 4'd9, 8'h00, 8'h00, 8'h00, 4'h0);
        tick(); tick();
        rx_byte(8'hA5);
        wait_rsp(10, n, vld, to, data);
        chk("post_rst_vld", {31'd0, vld}, 32'd1);
        chk("post_rst_data", {16'd0, data}, 32'h00A5);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
